// File: rtl/dcache_wbb_pkg.sv
// Shared types and constants for the dcache writeback buffer.
package dcache_wbb_pkg;
  localparam logic [1:0] OPTYPE_READ  = 2'b00;
  localparam logic [1:0] OPTYPE_WRITE = 2'b01;
  localparam int LINE_W   = 512;
  localparam int LINE_OFF = 6;
  localparam int ADDR_W   = 64;
  localparam int LADDR_W  = ADDR_W - LINE_OFF;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WB_REQ,
    WB_WAIT,
    RESP
  } wbb_state_e;
endpackage

// File: rtl/dcache_wbb_storage.sv
// Circular FIFO of dirty lines with a fully associative line-address match.
module dcache_wbb_storage
  import dcache_wbb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [LADDR_W-1:0]         lookup_addr,
  output logic                       hit,
  output logic [$clog2(DEPTH)-1:0]   hit_idx,
  output logic [LINE_W-1:0]          hit_data,
  output logic [LADDR_W-1:0]         head_addr,
  output logic [LINE_W-1:0]          head_data,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       enq_en,
  input  logic                       merge_en,
  input  logic [$clog2(DEPTH)-1:0]   merge_idx,
  input  logic [LINE_W-1:0]          wr_data,
  input  logic                       pop_en
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]   valid_reg;
  logic [LADDR_W-1:0] addr_mem [DEPTH];
  logic [LINE_W-1:0]  data_mem [DEPTH];
  logic [PTR_W-1:0]   head_reg, tail_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [DEPTH-1:0]   match;

  // Merging keeps line addresses unique, so at most one entry can match.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cam
    assign match[gi] = valid_reg[gi] && (addr_mem[gi] == lookup_addr);
  end

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) hit_idx = PTR_W'(i);
    end
  end

  assign hit       = |match;
  assign hit_data  = data_mem[hit_idx];
  assign head_addr = addr_mem[head_reg];
  assign head_data = data_mem[head_reg];
  assign count     = count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (enq_en) begin
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_reg + 1'b1;
      end
      if (pop_en) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(enq_en) - CNT_W'(pop_en);
    end
  end

  // Payload needs no reset: valid_reg gates every use of it.
  always_ff @(posedge clock) begin
    if (enq_en) begin
      addr_mem[tail_reg] <= lookup_addr;
      data_mem[tail_reg] <= wr_data;
    end else if (merge_en) begin
      data_mem[merge_idx] <= wr_data;
    end
  end
endmodule

// File: rtl/dcache_writeback_buffer.sv
// Writeback buffer between dcache and channel_arb: acks writebacks early,
// serves read hits from queued lines, and drains when idle or near full.
module dcache_writeback_buffer
  import dcache_wbb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int DRAIN_THRESH = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                up_index_valid,
  output logic                up_index_ready,
  input  logic [ADDR_W-1:0]   up_index,
  input  logic [LINE_W-1:0]   up_write_data,
  input  logic [1:0]          up_operation_type,
  output logic [LINE_W-1:0]   up_read_data,
  output logic                up_operation_done,
  output logic                dn_index_valid,
  input  logic                dn_index_ready,
  output logic [ADDR_W-1:0]   dn_index,
  output logic [LINE_W-1:0]   dn_write_data,
  output logic [1:0]          dn_operation_type,
  input  logic [LINE_W-1:0]   dn_read_data,
  input  logic                dn_operation_done
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbb_state_e         state_reg, state_next;
  logic [LADDR_W-1:0] rd_addr_reg;
  logic [LINE_W-1:0]  resp_data_reg;

  logic               hit;
  logic [PTR_W-1:0]   hit_idx;
  logic [LINE_W-1:0]  hit_data, head_data;
  logic [LADDR_W-1:0] head_addr;
  logic [CNT_W-1:0]   count;
  logic               enq_en, merge_en, pop_en;
  logic               force_drain, accept, up_is_write;

  assign force_drain    = (count >= CNT_W'(DRAIN_THRESH));
  assign up_index_ready = (state_reg == IDLE) && !force_drain;
  assign accept         = up_index_valid && up_index_ready;
  assign up_is_write    = (up_operation_type == OPTYPE_WRITE);

  dcache_wbb_storage #(.DEPTH(DEPTH)) u_storage (
    .clock       (clock),
    .reset_n     (reset_n),
    .lookup_addr (up_index[ADDR_W-1:LINE_OFF]),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .hit_data    (hit_data),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (count),
    .enq_en      (enq_en),
    .merge_en    (merge_en),
    .merge_idx   (hit_idx),
    .wr_data     (up_write_data),
    .pop_en      (pop_en)
  );

  always_comb begin
    state_next = state_reg;
    enq_en     = 1'b0;
    merge_en   = 1'b0;
    pop_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (up_is_write) begin
            merge_en   = hit;
            enq_en     = !hit;
            state_next = RESP;
          end else begin
            state_next = hit ? RESP : RD_REQ;
          end
        end else if (count != '0) begin
          // Reaching here means upstream is quiet or held off by force_drain.
          state_next = WB_REQ;
        end
      end
      RD_REQ:  if (dn_index_ready) state_next = RD_WAIT;
      RD_WAIT: if (dn_operation_done) state_next = RESP;
      WB_REQ:  if (dn_index_ready) state_next = WB_WAIT;
      WB_WAIT: begin
        if (dn_operation_done) begin
          pop_en     = 1'b1;
          state_next = IDLE;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      rd_addr_reg   <= '0;
      resp_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) rd_addr_reg <= up_index[ADDR_W-1:LINE_OFF];
      if (accept && !up_is_write && hit) resp_data_reg <= hit_data;
      if (state_reg == RD_WAIT && dn_operation_done) resp_data_reg <= dn_read_data;
    end
  end

  assign up_read_data      = resp_data_reg;
  assign up_operation_done = (state_reg == RESP);

  always_comb begin
    dn_index_valid    = 1'b0;
    dn_index          = '0;
    dn_write_data     = '0;
    dn_operation_type = OPTYPE_READ;
    case (state_reg)
      RD_REQ: begin
        dn_index_valid = 1'b1;
        dn_index       = {rd_addr_reg, {LINE_OFF{1'b0}}};
      end
      WB_REQ: begin
        dn_index_valid    = 1'b1;
        dn_index          = {head_addr, {LINE_OFF{1'b0}}};
        dn_write_data     = head_data;
        dn_operation_type = OPTYPE_WRITE;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dcache_writeback_buffer.sv
// Directed scoreboard bench for dcache_writeback_buffer.
module tb_dcache_writeback_buffer;
  import dcache_wbb_pkg::*;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         up_index_valid = 1'b0;
  logic         up_index_ready;
  logic [63:0]  up_index = '0;
  logic [511:0] up_write_data = '0;
  logic [1:0]   up_operation_type = 2'b00;
  logic [511:0] up_read_data;
  logic         up_operation_done;
  logic         dn_index_valid;
  logic         dn_index_ready = 1'b0;
  logic [63:0]  dn_index;
  logic [511:0] dn_write_data;
  logic [1:0]   dn_operation_type;
  logic [511:0] dn_read_data = '0;
  logic         dn_operation_done = 1'b0;

  dcache_writeback_buffer #(.DEPTH(4), .DRAIN_THRESH(3)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .up_index_valid    (up_index_valid),
    .up_index_ready    (up_index_ready),
    .up_index          (up_index),
    .up_write_data     (up_write_data),
    .up_operation_type (up_operation_type),
    .up_read_data      (up_read_data),
    .up_operation_done (up_operation_done),
    .dn_index_valid    (dn_index_valid),
    .dn_index_ready    (dn_index_ready),
    .dn_index          (dn_index),
    .dn_write_data     (dn_write_data),
    .dn_operation_type (dn_operation_type),
    .dn_read_data      (dn_read_data),
    .dn_operation_done (dn_operation_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [63:0]  addr;
    logic [1:0]   op;
    logic [511:0] data;
  } dn_txn_t;

  dn_txn_t      dn_q[$];
  logic [511:0] up_q[$];
  dn_txn_t      mon_t;
  logic [511:0] mon_d;
  int tests = 0, fails = 0, cyc = 0;
  int done_cnt = 0, exp_done = 0, dn_valid_cnt = 0;
  int last_done_cyc = -1, accept_cyc = 0, dn_done_cyc = 0, snap_done, snap_dn;
  logic [511:0] last_rd = '0;
  logic [511:0] a_line, b_line, c_line, d_line, e_line, r_line, l0, l1, l2;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int cnt_now();
    return int'(dut.u_storage.count);
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor: pops expected upstream responses and downstream requests.
  always @(negedge clock) begin
    if (reset_n) begin
      if (dn_index_valid) dn_valid_cnt++;
      if (dn_index_valid && dn_index_ready) begin
        chk("dn_q_nonempty", 512'(dn_q.size() != 0), 512'(1));
        if (dn_q.size() != 0) begin
          mon_t = dn_q.pop_front();
          chk("dn_index", 512'(dn_index), 512'(mon_t.addr));
          chk("dn_optype", 512'(dn_operation_type), 512'(mon_t.op));
          chk("dn_write_data", dn_write_data, mon_t.data);
        end
      end
      if (up_operation_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        chk("up_q_nonempty", 512'(up_q.size() != 0), 512'(1));
        if (up_q.size() != 0) begin
          mon_d = up_q.pop_front();
          chk("up_read_data", up_read_data, mon_d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic up_req(input logic [1:0] op, input logic [63:0] addr,
                        input logic [511:0] wd, input logic [511:0] rexp);
    int n = 0;
    up_index_valid = 1'b1; up_index = addr; up_write_data = wd; up_operation_type = op;
    forever begin
      @(negedge clock);
      if (up_index_ready) break;
      n++;
      if (n > 50) break;
    end
    if (n > 50) chk("up_ready_timeout", 512'(up_index_ready), 512'(1));
    else begin
      accept_cyc = cyc;
      if (op == OPTYPE_READ) last_rd = rexp;
      up_q.push_back(last_rd);
      exp_done++;
    end
    @(posedge clock); #1;
    up_index_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt < exp_done && n < 100) begin
      @(negedge clock); #1; n++;
    end
    chk("done_count", 512'(done_cnt), 512'(exp_done));
  endtask

  task automatic dn_grant();
    int n = 0;
    dn_index_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (dn_index_valid) break;
      n++;
      if (n > 50) break;
    end
    if (n > 50) chk("dn_valid_timeout", 512'(dn_index_valid), 512'(1));
    @(posedge clock); #1;
    dn_index_ready = 1'b0;
  endtask

  task automatic dn_done(input logic [511:0] rd);
    dn_operation_done = 1'b1; dn_read_data = rd; dn_done_cyc = cyc;
    tick();
    dn_operation_done = 1'b0; dn_read_data = '0;
  endtask

  task automatic push_dn(input logic [63:0] addr, input logic [1:0] op, input logic [511:0] d);
    dn_txn_t t;
    t.addr = addr; t.op = op; t.data = d;
    dn_q.push_back(t);
  endtask

  initial begin
    a_line = rnd_line(); b_line = rnd_line(); c_line = rnd_line(); d_line = rnd_line();
    e_line = rnd_line(); r_line = rnd_line(); l0 = rnd_line(); l1 = rnd_line(); l2 = rnd_line();
    tick(); tick();
    chk("rst_done", 512'(up_operation_done), 512'(0));
    chk("rst_read_data", up_read_data, 512'(0));
    chk("rst_dn_valid", 512'(dn_index_valid), 512'(0));
    chk("rst_dn_index", 512'(dn_index), 512'(0));
    chk("rst_dn_wdata", dn_write_data, 512'(0));
    chk("rst_count", 512'(cnt_now()), 512'(0));
    reset_n = 1'b1;
    tick();
    chk("idle_ready", 512'(up_index_ready), 512'(1));

    // Single write then drain.
    up_req(OPTYPE_WRITE, 64'h1000, a_line, '0);
    wait_done();
    chk("wr_latency", 512'(last_done_cyc), 512'(accept_cyc + 1));
    chk("count_after_wr", 512'(cnt_now()), 512'(1));
    push_dn(64'h1000, OPTYPE_WRITE, a_line);
    dn_grant();
    chk("wb_wait_no_valid", 512'(dn_index_valid), 512'(0));
    chk("count_in_wb_wait", 512'(cnt_now()), 512'(1));
    dn_done('0);
    chk("count_after_drain", 512'(cnt_now()), 512'(0));

    // Read hit on a queued line, different byte offset.
    up_req(OPTYPE_WRITE, 64'h2000, a_line, '0);
    wait_done();
    dn_valid_cnt = 0;
    up_req(OPTYPE_READ, 64'h2040 - 64'h40 + 64'h3f, '0, a_line);
    wait_done();
    chk("hit_latency", 512'(last_done_cyc), 512'(accept_cyc + 1));
    chk("hit_no_dn", 512'(dn_valid_cnt), 512'(0));
    push_dn(64'h2000, OPTYPE_WRITE, a_line);
    dn_grant(); dn_done('0);

    // Three writes with downstream stalled: force drain holds off upstream.
    up_req(OPTYPE_WRITE, 64'h0, l0, '0);  wait_done();
    up_req(OPTYPE_WRITE, 64'h40, l1, '0); wait_done();
    up_req(OPTYPE_WRITE, 64'h80, l2, '0); wait_done();
    chk("count_full3", 512'(cnt_now()), 512'(3));
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", 512'(dn_index_valid), 512'(1));
      chk("hold_index", 512'(dn_index), 512'(0));
      chk("hold_ready_low", 512'(up_index_ready), 512'(0));
      tick();
    end
    push_dn(64'h0, OPTYPE_WRITE, l0);
    dn_grant(); dn_done('0);

    // Read miss bypasses the two queued lines.
    up_req(OPTYPE_READ, 64'h3000, '0, r_line);
    push_dn(64'h3000, OPTYPE_READ, '0);
    dn_grant();
    tick();
    dn_done(r_line);
    wait_done();
    chk("miss_latency", 512'(last_done_cyc), 512'(dn_done_cyc + 1));
    push_dn(64'h40, OPTYPE_WRITE, l1);
    push_dn(64'h80, OPTYPE_WRITE, l2);
    dn_grant(); dn_done('0);
    dn_grant(); dn_done('0);
    chk("count_after_bypass", 512'(cnt_now()), 512'(0));

    // Merge of a rewritten line.
    up_req(OPTYPE_WRITE, 64'h4000, a_line, '0); wait_done();
    up_req(OPTYPE_WRITE, 64'h4000, b_line, '0); wait_done();
    chk("count_merge", 512'(cnt_now()), 512'(1));
    push_dn(64'h4000, OPTYPE_WRITE, b_line);
    dn_grant(); dn_done('0);

    // Reset during WB_WAIT with two lines queued.
    up_req(OPTYPE_WRITE, 64'h5000, c_line, '0); wait_done();
    up_req(OPTYPE_WRITE, 64'h5040, d_line, '0); wait_done();
    push_dn(64'h5000, OPTYPE_WRITE, c_line);
    dn_grant();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", 512'(dn_index_valid), 512'(0));
    chk("rst_mid_count", 512'(cnt_now()), 512'(0));
    chk("rst_mid_rdata", up_read_data, 512'(0));
    last_rd = '0;
    tick();
    reset_n = 1'b1;
    tick();
    snap_done = done_cnt; snap_dn = dn_valid_cnt;
    dn_done(e_line);
    repeat (4) tick();
    chk("stray_done_ignored", 512'(done_cnt), 512'(snap_done));
    chk("no_dn_after_rst", 512'(dn_valid_cnt), 512'(snap_dn));
    chk("ready_after_rst", 512'(up_index_ready), 512'(1));

    // Normal operation after reset.
    up_req(OPTYPE_WRITE, 64'h6000, e_line, '0); wait_done();
    up_req(OPTYPE_READ, 64'h6010, '0, e_line); wait_done();
    push_dn(64'h6000, OPTYPE_WRITE, e_line);
    dn_grant(); dn_done('0);
    tick();
    chk("up_q_drained", 512'(up_q.size()), 512'(0));
    chk("dn_q_drained", 512'(dn_q.size()), 512'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
